// File: rtl/periph_req_watchdog.sv
// Request/response watchdog between a core data port and the peripheral demux.
// Optional timeout statistics counter enabled by defining PERIPH_WDOG_STATS_EN.
module periph_req_watchdog #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst_i,
  // core side
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  output logic                  data_gnt_o,
  output logic                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic                  data_r_opc_o,
  // demux side
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                  data_wen_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  input  logic                  data_gnt_i,
  input  logic                  data_r_valid_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
  input  logic                  data_r_opc_i,
  // event / status
  output logic                  timeout_o,
  output logic [ADDR_WIDTH-1:0] err_add_o,
  output logic [15:0]           timeout_cnt_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitGnt,
    StWaitResp,
    StErrResp,
    StDrain
  } state_e;

  typedef enum logic {
    OrigGnt,
    OrigResp
  } origin_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  origin_e                 origin_q, origin_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   add_q, add_d;
  logic [ADDR_WIDTH-1:0]   err_add_q, err_add_d;
  logic                    cnt_hit;

  assign cnt_hit = (cnt_q == CntMax);

  // State register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      origin_q  <= OrigGnt;
      cnt_q     <= '0;
      add_q     <= '0;
      err_add_q <= '0;
    end else begin
      origin_q  <= origin_d;
      cnt_q     <= cnt_d;
      add_q     <= add_d;
      err_add_q <= err_add_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    origin_d  = origin_q;
    cnt_d     = cnt_q;
    add_d     = add_q;
    err_add_d = err_add_q;

    unique case (state_q)
      StIdle: begin
        if (data_req_i) begin
          add_d   = data_add_i;
          cnt_d   = '0;
          state_d = data_gnt_i ? StWaitResp : StWaitGnt;
        end
      end

      StWaitGnt: begin
        if (data_req_i) begin
          add_d = data_add_i;
        end
        if (data_gnt_i) begin
          cnt_d   = '0;
          state_d = StWaitResp;
        end else if (cnt_hit) begin
          origin_d = OrigGnt;
          state_d  = StErrResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StWaitResp: begin
        // A response on the last counted cycle still wins over the timeout.
        if (data_r_valid_i) begin
          state_d = StIdle;
        end else if (cnt_hit) begin
          origin_d = OrigResp;
          state_d  = StErrResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StErrResp: begin
        err_add_d = add_q;
        if (origin_q == OrigGnt || data_r_valid_i) begin
          state_d = StIdle;
        end else begin
          cnt_d   = '0;
          state_d = StDrain;
        end
      end

      StDrain: begin
        // Swallow a late response so it can never answer a newer request.
        if (data_r_valid_i || cnt_hit) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic
  always_comb begin
    data_req_o     = 1'b0;
    data_gnt_o     = 1'b0;
    data_r_valid_o = 1'b0;
    data_r_rdata_o = '0;
    data_r_opc_o   = 1'b0;
    timeout_o      = 1'b0;
    data_add_o     = data_add_i;
    data_wen_o     = data_wen_i;
    data_wdata_o   = data_wdata_i;
    data_be_o      = data_be_i;

    unique case (state_q)
      StIdle: begin
        data_req_o = data_req_i;
        data_gnt_o = data_gnt_i;
      end

      StWaitGnt: begin
        if (!data_gnt_i && cnt_hit) begin
          // Fake grant: withdraw from the demux, release the core.
          data_gnt_o = 1'b1;
        end else begin
          data_req_o = data_req_i;
          data_gnt_o = data_gnt_i;
        end
      end

      StWaitResp: begin
        data_r_valid_o = data_r_valid_i;
        data_r_rdata_o = data_r_rdata_i;
        data_r_opc_o   = data_r_opc_i;
      end

      StErrResp: begin
        data_r_valid_o = 1'b1;
        data_r_opc_o   = 1'b1;
        timeout_o      = 1'b1;
      end

      StDrain: begin
      end

      default: begin
      end
    endcase

    // Combinational forwarding paths must also read zero while reset is held.
    if (rst_i) begin
      data_req_o     = 1'b0;
      data_gnt_o     = 1'b0;
      data_r_valid_o = 1'b0;
      data_r_rdata_o = '0;
      data_r_opc_o   = 1'b0;
      timeout_o      = 1'b0;
      data_add_o     = '0;
      data_wen_o     = 1'b0;
      data_wdata_o   = '0;
      data_be_o      = '0;
    end
  end

  assign err_add_o = err_add_q;

`ifdef PERIPH_WDOG_STATS_EN
  logic [15:0] timeout_cnt_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      timeout_cnt_q <= '0;
    end else if (state_q == StErrResp && timeout_cnt_q != 16'hFFFF) begin
      timeout_cnt_q <= timeout_cnt_q + 16'd1;
    end
  end

  assign timeout_cnt_o = timeout_cnt_q;
`else
  assign timeout_cnt_o = '0;
`endif

endmodule

// File: tb/tb_periph_req_watchdog.sv
// Self-checking bench for periph_req_watchdog: response scoreboard plus directed
// checks of grant timeout, response timeout, drain, late response and reset.
module tb_periph_req_watchdog;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned TO = 64;

  logic          clk;
  logic          rst_i;
  logic          data_req_i;
  logic [AW-1:0] data_add_i;
  logic          data_wen_i;
  logic [DW-1:0] data_wdata_i;
  logic [BW-1:0] data_be_i;
  logic          data_gnt_o;
  logic          data_r_valid_o;
  logic [DW-1:0] data_r_rdata_o;
  logic          data_r_opc_o;
  logic          data_req_o;
  logic [AW-1:0] data_add_o;
  logic          data_wen_o;
  logic [DW-1:0] data_wdata_o;
  logic [BW-1:0] data_be_o;
  logic          data_gnt_i;
  logic          data_r_valid_i;
  logic [DW-1:0] data_r_rdata_i;
  logic          data_r_opc_i;
  logic          timeout_o;
  logic [AW-1:0] err_add_o;
  logic [15:0]   timeout_cnt_o;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          opc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_to_seen = 0;
  int   n_to_exp  = 0;

  periph_req_watchdog #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .BE_WIDTH      (BW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .data_req_i    (data_req_i),
    .data_add_i    (data_add_i),
    .data_wen_i    (data_wen_i),
    .data_wdata_i  (data_wdata_i),
    .data_be_i     (data_be_i),
    .data_gnt_o    (data_gnt_o),
    .data_r_valid_o(data_r_valid_o),
    .data_r_rdata_o(data_r_rdata_o),
    .data_r_opc_o  (data_r_opc_o),
    .data_req_o    (data_req_o),
    .data_add_o    (data_add_o),
    .data_wen_o    (data_wen_o),
    .data_wdata_o  (data_wdata_o),
    .data_be_o     (data_be_o),
    .data_gnt_i    (data_gnt_i),
    .data_r_valid_i(data_r_valid_i),
    .data_r_rdata_i(data_r_rdata_i),
    .data_r_opc_i  (data_r_opc_i),
    .timeout_o     (timeout_o),
    .err_add_o     (err_add_o),
    .timeout_cnt_o (timeout_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [DW-1:0] rdata, input logic opc);
    exp_t e;
    e.rdata = rdata;
    e.opc   = opc;
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    data_req_i     = 1'b0;
    data_add_i     = '0;
    data_wen_i     = 1'b0;
    data_wdata_i   = '0;
    data_be_i      = '0;
    data_gnt_i     = 1'b0;
    data_r_valid_i = 1'b0;
    data_r_rdata_i = '0;
    data_r_opc_i   = 1'b0;
  endtask

  // Response monitor: every core-visible response must match the scoreboard head.
  always @(negedge clk) begin
    if (data_r_valid_o) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_r_valid", {32'h0, data_r_rdata_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("resp_rdata", data_r_rdata_o, e.rdata);
        check_eq("resp_opc", data_r_opc_o, e.opc);
      end
    end
    if (timeout_o) n_to_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got running, expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    data_req_i = 1'b1;
    data_add_i = 32'h1234_5678;
    sample();
    check_eq("rst_req_o", data_req_o, 0);
    check_eq("rst_add_o", data_add_o, 0);
    next_cycle();
    rst_i = 1'b0;
    clear_inputs();
    sample();
    check_eq("post_rst_gnt", data_gnt_o, 0);
    check_eq("post_rst_rvalid", data_r_valid_o, 0);
    check_eq("post_rst_timeout", timeout_o, 0);
    check_eq("post_rst_err_add", err_add_o, 0);
    check_eq("post_rst_tcnt", timeout_cnt_o, 0);

    // Normal read, granted immediately, response three cycles later.
    next_cycle();
    data_req_i = 1'b1; data_add_i = 32'h1020_4000; data_wen_i = 1'b1;
    data_be_i = 4'hF; data_gnt_i = 1'b1;
    push_exp(32'hCAFE_0001, 1'b0);
    sample();
    check_eq("t1_req_fwd", data_req_o, 1);
    check_eq("t1_gnt", data_gnt_o, 1);
    check_eq("t1_add_fwd", data_add_o, 32'h1020_4000);
    check_eq("t1_wen_fwd", data_wen_o, 1);
    check_eq("t1_be_fwd", data_be_o, 4'hF);
    next_cycle();
    data_add_i = 32'h1020_4004;
    sample();
    check_eq("t1_outstanding_req", data_req_o, 0);
    check_eq("t1_outstanding_gnt", data_gnt_o, 0);
    check_eq("t1_add_fwd_wait", data_add_o, 32'h1020_4004);
    next_cycle();
    clear_inputs();
    next_cycle();
    data_r_valid_i = 1'b1; data_r_rdata_i = 32'hCAFE_0001;
    sample();
    check_eq("t1_rvalid", data_r_valid_o, 1);
    next_cycle();
    clear_inputs();
    sample();
    check_eq("t1_no_timeout", n_to_seen, n_to_exp);

    // Response lands on the last counted cycle: delivered normally.
    next_cycle();
    data_req_i = 1'b1; data_add_i = 32'h1020_4800; data_wen_i = 1'b1; data_gnt_i = 1'b1;
    push_exp(32'hCAFE_0040, 1'b0);
    next_cycle();
    clear_inputs();
    repeat (TO - 1) next_cycle();
    data_r_valid_i = 1'b1; data_r_rdata_i = 32'hCAFE_0040;
    sample();
    check_eq("t4_timeout_last", timeout_o, 0);
    check_eq("t4_rvalid_last", data_r_valid_o, 1);
    next_cycle();
    clear_inputs();
    sample();
    check_eq("t4_timeout_after", timeout_o, 0);
    check_eq("t4_rvalid_after", data_r_valid_o, 0);
    check_eq("t4_to_count", n_to_seen, n_to_exp);

    // Reset while a response is outstanding.
    next_cycle();
    data_req_i = 1'b1; data_add_i = 32'h1020_6000; data_wen_i = 1'b1; data_gnt_i = 1'b1;
    next_cycle();
    data_r_valid_i = 1'b0;
    rst_i = 1'b1;
    data_r_valid_i = 1'b1; data_r_rdata_i = 32'h5555_AAAA; data_r_opc_i = 1'b1;
    sample();
    check_eq("t5_rst_req", data_req_o, 0);
    check_eq("t5_rst_gnt", data_gnt_o, 0);
    check_eq("t5_rst_rvalid", data_r_valid_o, 0);
    check_eq("t5_rst_rdata", data_r_rdata_o, 0);
    check_eq("t5_rst_opc", data_r_opc_o, 0);
    check_eq("t5_rst_add", data_add_o, 0);
    next_cycle();
    rst_i = 1'b0;
    data_req_i = 1'b0; data_gnt_i = 1'b0;
    sample();
    check_eq("t5_idle_rvalid_ignored", data_r_valid_o, 0);
    next_cycle();
    clear_inputs();
    data_req_i = 1'b1; data_add_i = 32'h1020_6100; data_wen_i = 1'b1; data_gnt_i = 1'b1;
    push_exp(32'h0000_600D, 1'b0);
    sample();
    check_eq("t5_req_fwd", data_req_o, 1);
    check_eq("t5_gnt", data_gnt_o, 1);
    next_cycle();
    clear_inputs();
    data_r_valid_i = 1'b1; data_r_rdata_i = 32'h0000_600D;
    next_cycle();
    clear_inputs();

    // Grant timeout: demux never grants.
    next_cycle();
    data_req_i = 1'b1; data_add_i = 32'h1020_4C00; data_wen_i = 1'b1;
    sample();
    check_eq("t2_req_idle", data_req_o, 1);
    check_eq("t2_gnt_idle", data_gnt_o, 0);
    for (int i = 0; i < TO - 1; i++) begin
      next_cycle();
      sample();
      check_eq("t2_req_waiting", data_req_o, 1);
    end
    next_cycle();
    sample();
    check_eq("t2_fake_gnt", data_gnt_o, 1);
    check_eq("t2_req_withdrawn", data_req_o, 0);
    push_exp(32'h0, 1'b1);
    n_to_exp++;
    next_cycle();
    clear_inputs();
    sample();
    check_eq("t2_timeout", timeout_o, 1);
    next_cycle();
    sample();
    check_eq("t2_err_add", err_add_o, 32'h1020_4C00);
    check_eq("t2_timeout_pulse", timeout_o, 0);

    // Write granted, no response: error, drain, late response swallowed.
    next_cycle();
    data_req_i = 1'b1; data_add_i = 32'h1020_5000; data_wen_i = 1'b0;
    data_wdata_i = 32'hA5A5_0F0F; data_gnt_i = 1'b1;
    sample();
    check_eq("t3_gnt", data_gnt_o, 1);
    check_eq("t3_wdata_fwd", data_wdata_o, 32'hA5A5_0F0F);
    next_cycle();
    clear_inputs();
    repeat (TO - 1) next_cycle();
    sample();
    check_eq("t3_no_early_timeout", timeout_o, 0);
    push_exp(32'h0, 1'b1);
    n_to_exp++;
    next_cycle();
    sample();
    check_eq("t3_timeout", timeout_o, 1);
    repeat (5) next_cycle();
    data_r_valid_i = 1'b1; data_r_rdata_i = 32'hDEAD_BEEF;
    sample();
    check_eq("t3_drain_rvalid", data_r_valid_o, 0);
    check_eq("t3_drain_rdata", data_r_rdata_o, 0);
    check_eq("t3_err_add", err_add_o, 32'h1020_5000);
    next_cycle();
    clear_inputs();
    next_cycle();
    data_req_i = 1'b1; data_add_i = 32'h1020_5100; data_wen_i = 1'b1; data_gnt_i = 1'b1;
    push_exp(32'h1234_5678, 1'b0);
    sample();
    check_eq("t3_new_gnt", data_gnt_o, 1);
    next_cycle();
    clear_inputs();
    data_r_valid_i = 1'b1; data_r_rdata_i = 32'h1234_5678;
    next_cycle();
    clear_inputs();

    // Response timeout with a stale response during the error cycle: no drain.
    next_cycle();
    data_req_i = 1'b1; data_add_i = 32'h1020_7000; data_wen_i = 1'b1; data_gnt_i = 1'b1;
    next_cycle();
    clear_inputs();
    repeat (TO - 1) next_cycle();
    push_exp(32'h0, 1'b1);
    n_to_exp++;
    next_cycle();
    data_r_valid_i = 1'b1; data_r_rdata_i = 32'h0BAD_0BAD;
    sample();
    check_eq("t6_timeout", timeout_o, 1);
    check_eq("t6_err_rdata", data_r_rdata_o, 0);
    next_cycle();
    clear_inputs();
    data_req_i = 1'b1; data_add_i = 32'h1020_7100; data_wen_i = 1'b1; data_gnt_i = 1'b1;
    push_exp(32'h0000_7777, 1'b0);
    sample();
    check_eq("t6_gnt_no_drain", data_gnt_o, 1);
    next_cycle();
    clear_inputs();
    data_r_valid_i = 1'b1; data_r_rdata_i = 32'h0000_7777;
    next_cycle();
    clear_inputs();
    repeat (2) next_cycle();
    sample();

    check_eq("err_add_final", err_add_o, 32'h1020_7000);
    check_eq("timeout_pulses", n_to_seen, n_to_exp);
`ifdef PERIPH_WDOG_STATS_EN
    check_eq("stats_cnt", timeout_cnt_o, n_to_exp);
`else
    check_eq("stats_cnt", timeout_cnt_o, 0);
`endif
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
